regfile_access_ctrl: RTL and testbench

Sequences and arbitrates all accesses to the 32x32 PE register file (1 write port, 2 read ports, registered write enables). Two requesters share it: the PE core (writeback and operand reads) and the CGRA host/debug port (single-register read or write). Sits between the PE pipeline/host interface and register_system; drives its select, data, rdwrite, read_en and reg_select inputs.

---
 rtl/pe_rf_pkg.sv | 30 +++
 rtl/rf_starve_arb.sv | 57 +++++
 rtl/regfile_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_rf_pkg.sv
// Shared types and constants for the PE register-file access controller.
`timescale 1ns/1ps
package pe_rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   // One-hot grant vector bit positions produced by the arbiter
   localparam int GNT_W       = 3;
   localparam int GNT_CORE_WR = 0;
   localparam int GNT_CORE_RD = 1;
   localparam int GNT_HOST    = 2;

   typedef enum logic [1:0] {IDLE, WRITE, READ} rf_state_e;

   typedef enum logic [1:0] {REQ_NONE, REQ_CORE_WR, REQ_CORE_RD, REQ_HOST} req_e;

   // Collapse the one-hot grant into a requester code
   function automatic req_e gnt_to_req(input logic [GNT_W-1:0] gnt);
      if (gnt[GNT_HOST])
         return REQ_HOST;
      else if (gnt[GNT_CORE_WR])
         return REQ_CORE_WR;
      else if (gnt[GNT_CORE_RD])
         return REQ_CORE_RD;
      else
         return REQ_NONE;
   endfunction

endpackage

// File: rtl/rf_starve_arb.sv
// Fixed-priority arbiter (core write > core read > host) with a starvation
// counter that forces the host through after STARVE_LIMIT core grants.
`timescale 1ns/1ps
module rf_starve_arb
   import pe_rf_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arb_en_i,
   input  logic             core_wr_valid_i,
   input  logic             core_rd_valid_i,
   input  logic             host_valid_i,
   output logic [GNT_W-1:0] grant_o
);

   localparam int CNT_W = 4;

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             starved;

   // Priority selection; the host jumps the queue once it has waited long enough
   always_comb begin
      starved = (starve_q == CNT_W'(STARVE_LIMIT)) && host_valid_i;
      grant_o = '0;
      if (arb_en_i) begin
         if (starved)
            grant_o[GNT_HOST] = 1'b1;
         else if (core_wr_valid_i)
            grant_o[GNT_CORE_WR] = 1'b1;
         else if (core_rd_valid_i)
            grant_o[GNT_CORE_RD] = 1'b1;
         else if (host_valid_i)
            grant_o[GNT_HOST] = 1'b1;
      end
   end

   // Count core grants that overtake a waiting host; any host grant or idle host clears
   always_comb begin
      starve_d = starve_q;
      if (!host_valid_i || grant_o[GNT_HOST])
         starve_d = '0;
      else if ((grant_o[GNT_CORE_WR] || grant_o[GNT_CORE_RD]) &&
               (starve_q != CNT_W'(STARVE_LIMIT)))
         starve_d = starve_q + 1'b1;
   end

   // Starvation counter state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve_q <= '0;
      else
         starve_q <= starve_d;
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences core and host accesses to the 32x32 PE register file, one at a
// time: writes hold the write enable for WR_HOLD cycles, reads take one
// READ cycle and respond the cycle after.
`timescale 1ns/1ps
module regfile_access_ctrl
   import pe_rf_pkg::*;
#(
   parameter int WR_HOLD      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  core_wr_valid,
   output logic                  core_wr_ready,
   input  logic [REG_ADDR_W-1:0] core_wr_addr,
   input  logic [XLEN-1:0]       core_wr_data,
   input  logic                  core_rd_valid,
   output logic                  core_rd_ready,
   input  logic [REG_ADDR_W-1:0] core_rs1,
   input  logic [REG_ADDR_W-1:0] core_rs2,
   input  logic                  core_rd_two,
   output logic                  core_rsp_valid,
   output logic [XLEN-1:0]       core_rs1_data,
   output logic [XLEN-1:0]       core_rs2_data,
   input  logic                  host_valid,
   output logic                  host_ready,
   input  logic                  host_we,
   input  logic [REG_ADDR_W-1:0] host_addr,
   input  logic [XLEN-1:0]       host_wdata,
   output logic                  host_rsp_valid,
   output logic [XLEN-1:0]       host_rdata,
   output logic [REG_ADDR_W-1:0] rf_selRD,
   output logic [REG_ADDR_W-1:0] rf_selRS1,
   output logic [REG_ADDR_W-1:0] rf_selRS2,
   output logic                  rf_reg_select,
   output logic [XLEN-1:0]       rf_data_in,
   output logic                  rf_rdwrite,
   output logic                  rf_read_en,
   input  logic [XLEN-1:0]       rf_data_out1,
   input  logic [XLEN-1:0]       rf_data_out2
);

   localparam int HOLD_W = 3;

   rf_state_e             state_q;
   logic [HOLD_W-1:0]     hold_q;
   logic                  is_host_q;
   logic [REG_ADDR_W-1:0] rf_selRD_q, rf_selRS1_q, rf_selRS2_q;
   logic [XLEN-1:0]       rf_data_in_q;
   logic                  rf_rdwrite_q, rf_read_en_q, rf_reg_select_q;
   logic                  core_rsp_valid_q, host_rsp_valid_q;
   logic [XLEN-1:0]       core_rs1_data_q, core_rs2_data_q, host_rdata_q;

   logic [GNT_W-1:0]      grant;
   logic                  arb_en;
   req_e                  req;
   logic                  wr_req;
   logic [REG_ADDR_W-1:0] wr_addr, rd_rs1, rd_rs2;
   logic [XLEN-1:0]       wr_data;
   logic                  rd_two;

   // Arbitration only happens in IDLE and never while reset is held
   assign arb_en = (state_q == IDLE) && !reset;

   rf_starve_arb #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk             (clk),
      .reset           (reset),
      .arb_en_i        (arb_en),
      .core_wr_valid_i (core_wr_valid),
      .core_rd_valid_i (core_rd_valid),
      .host_valid_i    (host_valid),
      .grant_o         (grant)
   );

   assign core_wr_ready = grant[GNT_CORE_WR];
   assign core_rd_ready = grant[GNT_CORE_RD];
   assign host_ready    = grant[GNT_HOST];

   // Steer the winning requester's fields onto a common write/read request
   always_comb begin
      req     = gnt_to_req(grant);
      wr_req  = (req == REQ_CORE_WR) || ((req == REQ_HOST) && host_we);
      wr_addr = (req == REQ_HOST) ? host_addr  : core_wr_addr;
      wr_data = (req == REQ_HOST) ? host_wdata : core_wr_data;
      rd_rs1  = (req == REQ_HOST) ? host_addr  : core_rs1;
      rd_rs2  = (req == REQ_HOST) ? '0         : core_rs2;
      rd_two  = (req == REQ_HOST) ? 1'b0       : core_rd_two;
   end

   // Access FSM with all register-file and response outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         hold_q           <= '0;
         is_host_q        <= 1'b0;
         rf_selRD_q       <= '0;
         rf_selRS1_q      <= '0;
         rf_selRS2_q      <= '0;
         rf_data_in_q     <= '0;
         rf_rdwrite_q     <= 1'b0;
         rf_read_en_q     <= 1'b0;
         rf_reg_select_q  <= 1'b0;
         core_rsp_valid_q <= 1'b0;
         host_rsp_valid_q <= 1'b0;
         core_rs1_data_q  <= '0;
         core_rs2_data_q  <= '0;
         host_rdata_q     <= '0;
      end else begin
         core_rsp_valid_q <= 1'b0;
         host_rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req != REQ_NONE) begin
                  is_host_q <= (req == REQ_HOST);
                  if (wr_req) begin
                     if (wr_addr != '0) begin
                        state_q      <= WRITE;
                        rf_selRD_q   <= wr_addr;
                        rf_data_in_q <= wr_data;
                        rf_rdwrite_q <= 1'b1;
                        hold_q       <= HOLD_W'(WR_HOLD - 1);
                        // With a single hold cycle it is already the last one
                        if ((WR_HOLD == 1) && (req == REQ_HOST)) begin
                           host_rsp_valid_q <= 1'b1;
                           host_rdata_q     <= '0;
                        end
                     end else if (req == REQ_HOST) begin
                        // x0 is read-only: acknowledge without touching the file
                        host_rsp_valid_q <= 1'b1;
                        host_rdata_q     <= '0;
                     end
                  end else begin
                     state_q         <= READ;
                     rf_selRS1_q     <= rd_rs1;
                     rf_selRS2_q     <= rd_rs2;
                     rf_reg_select_q <= rd_two;
                     rf_read_en_q    <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (hold_q == '0) begin
                  state_q      <= IDLE;
                  rf_rdwrite_q <= 1'b0;
               end else begin
                  hold_q <= hold_q - 1'b1;
                  // Host write completion lines up with the final hold cycle
                  if ((hold_q == HOLD_W'(1)) && is_host_q) begin
                     host_rsp_valid_q <= 1'b1;
                     host_rdata_q     <= '0;
                  end
               end
            end
            READ: begin
               state_q         <= IDLE;
               rf_read_en_q    <= 1'b0;
               rf_reg_select_q <= 1'b0;
               if (is_host_q) begin
                  host_rsp_valid_q <= 1'b1;
                  host_rdata_q     <= (rf_selRS1_q == '0) ? '0 : rf_data_out1;
               end else begin
                  core_rsp_valid_q <= 1'b1;
                  core_rs1_data_q  <= (rf_selRS1_q == '0) ? '0 : rf_data_out1;
                  core_rs2_data_q  <= (rf_reg_select_q && (rf_selRS2_q != '0)) ?
                                      rf_data_out2 : '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rf_selRD       = rf_selRD_q;
   assign rf_selRS1      = rf_selRS1_q;
   assign rf_selRS2      = rf_selRS2_q;
   assign rf_reg_select  = rf_reg_select_q;
   assign rf_data_in     = rf_data_in_q;
   assign rf_rdwrite     = rf_rdwrite_q;
   assign rf_read_en     = rf_read_en_q;
   assign core_rsp_valid = core_rsp_valid_q;
   assign core_rs1_data  = core_rs1_data_q;
   assign core_rs2_data  = core_rs2_data_q;
   assign host_rsp_valid = host_rsp_valid_q;
   assign host_rdata     = host_rdata_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl: grants push expected write
// cycles, read phases and responses; monitors pop and compare.
`timescale 1ns/1ps
module tb_regfile_access_ctrl;

   localparam int WR_HOLD      = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        core_wr_valid = 1'b0, core_wr_ready;
   logic [4:0]  core_wr_addr = '0;
   logic [31:0] core_wr_data = '0;
   logic        core_rd_valid = 1'b0, core_rd_ready;
   logic [4:0]  core_rs1 = '0, core_rs2 = '0;
   logic        core_rd_two = 1'b0;
   logic        core_rsp_valid;
   logic [31:0] core_rs1_data, core_rs2_data;
   logic        host_valid = 1'b0, host_ready, host_we = 1'b0;
   logic [4:0]  host_addr = '0;
   logic [31:0] host_wdata = '0;
   logic        host_rsp_valid;
   logic [31:0] host_rdata;
   logic [4:0]  rf_selRD, rf_selRS1, rf_selRS2;
   logic        rf_reg_select, rf_rdwrite, rf_read_en;
   logic [31:0] rf_data_in, rf_data_out1, rf_data_out2;

   always #5 clk = ~clk;

   regfile_access_ctrl #(.WR_HOLD(WR_HOLD), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .core_wr_valid(core_wr_valid), .core_wr_ready(core_wr_ready),
      .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
      .core_rd_valid(core_rd_valid), .core_rd_ready(core_rd_ready),
      .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd_two(core_rd_two),
      .core_rsp_valid(core_rsp_valid), .core_rs1_data(core_rs1_data),
      .core_rs2_data(core_rs2_data),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rsp_valid(host_rsp_valid), .host_rdata(host_rdata),
      .rf_selRD(rf_selRD), .rf_selRS1(rf_selRS1), .rf_selRS2(rf_selRS2),
      .rf_reg_select(rf_reg_select), .rf_data_in(rf_data_in),
      .rf_rdwrite(rf_rdwrite), .rf_read_en(rf_read_en),
      .rf_data_out1(rf_data_out1), .rf_data_out2(rf_data_out2)
   );

   // Register file model: combinational reads, write captured on the clock edge
   logic [31:0] rf_mem [32];
   assign rf_data_out1 = rf_mem[rf_selRS1];
   assign rf_data_out2 = rf_mem[rf_selRS2];
   always @(posedge clk) if (rf_rdwrite) rf_mem[rf_selRD] <= rf_data_in;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; logic [31:0] d1; logic [31:0] d2; } rsp_t;
   typedef struct { int due; logic [4:0] addr; logic [31:0] data; } wr_t;
   typedef struct { int due; logic [4:0] s1; logic [4:0] s2; logic two; logic chk2; } rdp_t;

   rsp_t  core_q[$], host_q[$];
   wr_t   wr_q[$];
   rdp_t  rdp_q[$];
   string glog;

   int checks = 0, errors = 0;

   logic [31:0] cr_exp1, cr_exp2, h_exp;
   logic        cr_hold = 1'b0;
   logic        cwr_g = 1'b0, crd_g = 1'b0, h_g = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[%0d] FAIL %s: got %0h expected %0h", cyc, name, act, exp);
      end else
         $display("[%0d] ok   %s = %0h", cyc, name, act);
   endtask

   task automatic chk_log(string exp);
      checks++;
      if (glog != exp) begin
         errors++;
         $display("[%0d] FAIL grant_order: got '%s' expected '%s'", cyc, glog, exp);
      end else
         $display("[%0d] ok   grant_order = %s", cyc, glog);
   endtask

   function automatic logic any_output();
      return |{core_wr_ready, core_rd_ready, core_rsp_valid, core_rs1_data, core_rs2_data,
               host_ready, host_rsp_valid, host_rdata, rf_selRD, rf_selRS1, rf_selRS2,
               rf_reg_select, rf_data_in, rf_rdwrite, rf_read_en};
   endfunction

   // Grant observer: releases granted requests and pushes expectations
   always begin
      @(negedge clk);
      if (cwr_g) begin core_wr_valid = 1'b0; cwr_g = 1'b0; end
      if (crd_g) begin core_rd_valid = 1'b0; crd_g = 1'b0; end
      if (h_g)   begin host_valid    = 1'b0; h_g   = 1'b0; end
      #2;
      if (!reset && (core_wr_ready || core_rd_ready || host_ready)) begin
         chk("one_ready", 32'($countones({core_wr_ready, core_rd_ready, host_ready})), 32'd1);
         if (core_wr_ready) begin
            chk("wr_ready_has_valid", 32'(core_wr_valid), 32'd1);
            glog = {glog, "W"};
            if (core_wr_addr != 5'd0)
               for (int k = 1; k <= WR_HOLD; k++) wr_q.push_back('{cyc + k, core_wr_addr, core_wr_data});
            cwr_g = 1'b1;
         end
         if (core_rd_ready) begin
            chk("rd_ready_has_valid", 32'(core_rd_valid), 32'd1);
            glog = {glog, "R"};
            rdp_q.push_back('{cyc + 1, core_rs1, core_rs2, core_rd_two, core_rd_two});
            core_q.push_back('{cyc + 2, cr_exp1, cr_exp2});
            if (!cr_hold) crd_g = 1'b1;
         end
         if (host_ready) begin
            chk("host_ready_has_valid", 32'(host_valid), 32'd1);
            glog = {glog, "H"};
            if (host_we) begin
               if (host_addr != 5'd0) begin
                  for (int k = 1; k <= WR_HOLD; k++) wr_q.push_back('{cyc + k, host_addr, host_wdata});
                  host_q.push_back('{cyc + WR_HOLD, 32'd0, 32'd0});
               end else
                  host_q.push_back('{cyc + 1, 32'd0, 32'd0});
            end else begin
               rdp_q.push_back('{cyc + 1, host_addr, 5'd0, 1'b0, 1'b0});
               host_q.push_back('{cyc + 2, h_exp, 32'd0});
            end
            h_g = 1'b1;
         end
      end
   end

   // Output monitor: every write cycle, read phase and response is matched
   wr_t  m_wr;
   rdp_t m_rd;
   rsp_t m_rsp;
   always begin
      @(negedge clk);
      if (!reset) begin
         if (rf_rdwrite) begin
            if (wr_q.size() == 0) chk("unexpected_rf_rdwrite", 32'(rf_selRD), 32'hFFFF_FFFF);
            else begin
               m_wr = wr_q.pop_front();
               chk("wr_cycle", cyc, m_wr.due);
               chk("wr_selRD", 32'(rf_selRD), 32'(m_wr.addr));
               chk("wr_data_in", rf_data_in, m_wr.data);
            end
         end
         if (rf_read_en) begin
            if (rdp_q.size() == 0) chk("unexpected_rf_read_en", 32'(rf_selRS1), 32'hFFFF_FFFF);
            else begin
               m_rd = rdp_q.pop_front();
               chk("rd_cycle", cyc, m_rd.due);
               chk("rd_selRS1", 32'(rf_selRS1), 32'(m_rd.s1));
               chk("rd_reg_select", 32'(rf_reg_select), 32'(m_rd.two));
               if (m_rd.chk2) chk("rd_selRS2", 32'(rf_selRS2), 32'(m_rd.s2));
            end
         end
         if (core_rsp_valid) begin
            if (core_q.size() == 0) chk("unexpected_core_rsp", core_rs1_data, 32'hFFFF_FFFF);
            else begin
               m_rsp = core_q.pop_front();
               chk("core_rsp_cycle", cyc, m_rsp.due);
               chk("core_rs1_data", core_rs1_data, m_rsp.d1);
               chk("core_rs2_data", core_rs2_data, m_rsp.d2);
            end
         end
         if (host_rsp_valid) begin
            if (host_q.size() == 0) chk("unexpected_host_rsp", host_rdata, 32'hFFFF_FFFF);
            else begin
               m_rsp = host_q.pop_front();
               chk("host_rsp_cycle", cyc, m_rsp.due);
               chk("host_rdata", host_rdata, m_rsp.d1);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic req_cwr(logic [4:0] a, logic [31:0] d);
      core_wr_addr = a; core_wr_data = d; core_wr_valid = 1'b1;
   endtask

   task automatic req_crd(logic [4:0] s1, logic [4:0] s2, logic two, logic [31:0] e1, logic [31:0] e2);
      core_rs1 = s1; core_rs2 = s2; core_rd_two = two;
      cr_exp1 = e1; cr_exp2 = e2; core_rd_valid = 1'b1;
   endtask

   task automatic req_host(logic we, logic [4:0] a, logic [31:0] wd, logic [31:0] e);
      host_we = we; host_addr = a; host_wdata = wd; h_exp = e; host_valid = 1'b1;
   endtask

   task automatic wait_host_free();
      int n = 0;
      while (host_valid && n < 50) begin step(); n++; end
      chk("host_grant_in_time", 32'(host_valid), 32'd0);
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((core_wr_valid || core_rd_valid || host_valid || core_q.size() != 0 ||
              host_q.size() != 0 || wr_q.size() != 0 || rdp_q.size() != 0) && n < 100) begin
         step(); n++;
      end
      chk("scoreboard_drained", 32'(core_q.size() + host_q.size() + wr_q.size() + rdp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
      rf_mem[0] = 32'hBAD0_BAD0;
      rf_mem[3] = 32'd7;
      rf_mem[4] = 32'd9;
      rf_mem[9] = 32'h11;

      // Reset state
      step();
      chk("reset_outputs_zero", 32'(any_output()), 32'd0);
      step();
      reset = 1'b0;
      step();

      // Host write x5 then host read-back
      glog = "";
      req_host(1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0);
      wait_host_free();
      req_host(1'b0, 5'd5, 32'd0, 32'hDEAD_BEEF);
      wait_quiet();
      chk_log("HH");

      // Core write to x0 is swallowed; read of x0 returns zero
      glog = "";
      step();
      req_cwr(5'd0, 32'h1234);
      wait_quiet();
      req_crd(5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
      wait_quiet();
      chk_log("WR");

      // Two-operand and single-operand core reads
      glog = "";
      req_crd(5'd3, 5'd4, 1'b1, 32'd7, 32'd9);
      wait_quiet();
      req_crd(5'd3, 5'd4, 1'b0, 32'd7, 32'd0);
      wait_quiet();
      chk_log("RR");

      // Starvation: held core reads let the host through every STARVE_LIMIT grants
      glog = "";
      step();
      cr_hold = 1'b1;
      req_crd(5'd3, 5'd4, 1'b1, 32'd7, 32'd9);
      req_host(1'b0, 5'd3, 32'd0, 32'd7);
      wait_host_free();
      req_host(1'b0, 5'd4, 32'd0, 32'd9);
      wait_host_free();
      cr_hold = 1'b0;
      core_rd_valid = 1'b0;
      wait_quiet();
      chk_log("RRRRHRRRRH");

      // Same-cycle write, core read and host read of x7
      glog = "";
      step();
      req_cwr(5'd7, 32'hA5);
      req_crd(5'd7, 5'd0, 1'b0, 32'hA5, 32'd0);
      req_host(1'b0, 5'd7, 32'd0, 32'hA5);
      wait_quiet();
      chk_log("WRH");

      // Reset during the first write hold cycle discards the write
      glog = "";
      step();
      req_host(1'b1, 5'd9, 32'h55, 32'd0);
      begin
         int n = 0;
         while (!rf_rdwrite && n < 20) begin step(); n++; end
      end
      chk("write_started", 32'(rf_rdwrite), 32'd1);
      reset = 1'b1;
      #1;
      chk("rdwrite_async_drop", 32'(rf_rdwrite), 32'd0);
      chk("midreset_outputs_zero", 32'(any_output()), 32'd0);
      wr_q.delete(); host_q.delete(); core_q.delete(); rdp_q.delete();
      step();
      step();
      chk("held_reset_outputs_zero", 32'(any_output()), 32'd0);
      reset = 1'b0;
      step();
      chk("x9_not_written", rf_mem[9], 32'h11);
      req_host(1'b0, 5'd9, 32'd0, 32'h11);
      wait_quiet();
      chk_log("HH");

      repeat (4) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
